// File: rtl/phy_tx_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_pkg
// Shared definitions for the PHY transmit-side scheduling logic.
//   - phy_state_t : scheduler FSM state encoding (ST_IDLE, ST_GRANT)
//   - PHY_LANES   : number of lanes feeding the transmit path
//   - PHY_IDLE_SYM: default symbol driven when no byte is transferred
// -----------------------------------------------------------------------------
package phy_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } phy_state_t;

    localparam int PHY_LANES = 4;

    localparam logic [7:0] PHY_IDLE_SYM = 8'hBC;

endpackage : phy_tx_pkg

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way round-robin picker. The winner is the first requesting
// lane found searching upward from i_ptr+1, modulo 4, so the lane named by
// i_ptr has the lowest priority.
// Ports:
//   i_req [3:0] : request vector, one bit per lane
//   i_ptr [1:0] : last-served lane
//   o_idx [1:0] : winning lane index (equals i_ptr when nothing requests)
//   o_any       : at least one lane requests
// -----------------------------------------------------------------------------
module rr_pick4
    import phy_tx_pkg::*;
(
    input  logic [PHY_LANES-1:0] i_req,
    input  logic [1:0]           i_ptr,
    output logic [1:0]           o_idx,
    output logic                 o_any
);

    logic [1:0] w_cand;

    // Walk from the lowest priority (offset 4 == ptr itself) to the highest
    // (offset 1); later hits overwrite earlier ones so the nearest wins.
    always_comb begin
        o_idx  = i_ptr;
        w_cand = i_ptr;
        for (int k = PHY_LANES; k >= 1; k--) begin
            w_cand = i_ptr + 2'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

    assign o_any = |i_req;

endmodule : rr_pick4

// File: rtl/phy_tx_sched.sv
// -----------------------------------------------------------------------------
// phy_tx_sched
// Round-robin scheduler granting the shared PHY transmit path to one of four
// byte lanes at a time, for bursts of at most BURST_MAX beats. One IDLE
// (arbitration) cycle separates consecutive grants.
//
// Optional feature macro: PHY_TX_SCHED_IDLE_SYM_EN
//   defined   : data_out is driven to IDLE_SYM on every non-beat cycle and in
//               reset.
//   undefined : data_out holds its last value on non-beat cycles; reset to 0.
//
// Parameters:
//   DATA_W    : lane / output byte width
//   BURST_MAX : maximum beats per grant (1..15)
//   IDLE_SYM  : idle symbol used when the macro is defined
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   In0..In3          : lane data
//   valid0..valid3    : lane has a byte to send
//   ready0..ready3    : lane byte accepted this cycle (granted lane only)
//   data_out          : registered scheduled byte
//   valid_out         : data_out holds a transferred byte
//   grant             : index of current / most recent granted lane
//   busy              : scheduler is in GRANT
// -----------------------------------------------------------------------------
module phy_tx_sched
    import phy_tx_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                BURST_MAX = 4,
    parameter logic [DATA_W-1:0] IDLE_SYM  = DATA_W'(PHY_IDLE_SYM)
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] In0,
    input  logic [DATA_W-1:0] In1,
    input  logic [DATA_W-1:0] In2,
    input  logic [DATA_W-1:0] In3,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              valid2,
    input  logic              valid3,
    output logic              ready0,
    output logic              ready1,
    output logic              ready2,
    output logic              ready3,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        grant,
    output logic              busy
);

`ifdef PHY_TX_SCHED_IDLE_SYM_EN
    localparam bit IDLE_SYM_EN = 1'b1;
`else
    localparam bit IDLE_SYM_EN = 1'b0;
`endif

    localparam int                CNT_W    = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [DATA_W-1:0] RST_DATA = IDLE_SYM_EN ? IDLE_SYM : '0;

    // Registered state
    phy_state_t        r_state;
    logic [1:0]        r_ptr;
    logic [1:0]        r_grant;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;

    // Lane fan-in and decoded handshake
    logic [DATA_W-1:0]    w_in [PHY_LANES];
    logic [PHY_LANES-1:0] w_valid;
    logic [PHY_LANES-1:0] w_ready;
    logic                 w_busy;
    logic [1:0]           w_pick;
    logic                 w_any;
    logic                 w_beat;
    logic [DATA_W-1:0]    w_sel_data;

    assign w_in[0] = In0;
    assign w_in[1] = In1;
    assign w_in[2] = In2;
    assign w_in[3] = In3;
    assign w_valid = {valid3, valid2, valid1, valid0};

    assign w_busy = (r_state == ST_GRANT);

    // Ready comes from registered state only; it must not loop back through
    // a lane's valid.
    generate
        for (genvar gi = 0; gi < PHY_LANES; gi++) begin : g_ready
            assign w_ready[gi] = w_busy && (r_grant == 2'(gi));
        end
    endgenerate

    assign w_sel_data = w_in[r_grant];
    assign w_beat     = w_busy && w_valid[r_grant];

    rr_pick4 u_pick (
        .i_req (w_valid),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd3;          // lane 0 wins the first arbitration
            r_grant     <= 2'd0;
            r_beat_cnt  <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= RST_DATA;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid_out <= 1'b0;
                    if (IDLE_SYM_EN) begin
                        r_data_out <= IDLE_SYM;
                    end
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_ptr      <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_beat) begin
                        r_data_out  <= w_sel_data;
                        r_valid_out <= 1'b1;
                        r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
                        if (r_beat_cnt == CNT_LAST) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        // Granted lane went quiet: release at once, no waiting.
                        r_valid_out <= 1'b0;
                        if (IDLE_SYM_EN) begin
                            r_data_out <= IDLE_SYM;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready0    = w_ready[0];
    assign ready1    = w_ready[1];
    assign ready2    = w_ready[2];
    assign ready3    = w_ready[3];
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign grant     = r_grant;
    assign busy      = w_busy;

endmodule : phy_tx_sched
